oto_pilot_pwm: RTL and testbench
================================

OTO_PILOT_PWM -- requirements
Module: oto_pilot_pwm

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of PWM actuator channels (1..8).
REQ-002 SHALL have parameter DUTY_W, default 8, duty/period counter width.
REQ-003 SHALL have parameter PRESC_W, default 8, prescaler width.
REQ-004 SHALL have parameter SLEW, default 4, maximum duty change per PWM period.
REQ-005 SHALL have port: clock  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: enable  input  1  run control.
REQ-008 SHALL have port: prescale  input  PRESC_W  ticks per period step, minus 1.
REQ-009 SHALL have port: cmd_valid  input  1  command offered.
REQ-010 SHALL have port: cmd_ready  output  1  command slot free.
REQ-011 SHALL have port: cmd_ch  input  $clog2(NUM_CH) (min 1)  target channel.
REQ-012 SHALL have port: cmd_duty  input  DUTY_W  requested duty.
REQ-013 SHALL have port: pwm_out  output  NUM_CH  PWM waveforms, registered.
REQ-014 SHALL have port: pwm_oeb  output  NUM_CH  pad output enable, active-low.
REQ-015 SHALL have port: err  output  1  sticky bad-channel flag.

Function
REQ-016 Prescaler counter SHALL count 0..prescale_q, producing a one-cycle tick when it equals prescale_q, then wrap to 0.
REQ-017 prescale_q SHALL load from prescale on the enable rising edge and at every period_end.
REQ-018 Period counter SHALL advance on tick over 0..2^DUTY_W-2 (period = 2^DUTY_W-1 ticks); period_end SHALL pulse on the tick where it wraps to 0.
REQ-019 Command accepted when cmd_valid && cmd_ready; ch/duty SHALL be stored in a one-entry pending register, and cmd_ready SHALL be !pending.
REQ-020 At period_end with pending set: target[ch] <= duty, pending cleared, cmd_ready high next cycle.
REQ-021 An accept in the same cycle as period_end SHALL be stored and applied at the following period_end.
REQ-022 cmd_ch >= NUM_CH SHALL be accepted normally, discarded at application, and set err (cleared only by reset).
REQ-023 At each period_end every channel's current duty SHALL move toward target by min(|target-current|, SLEW), using unsigned arithmetic without wrap.
REQ-024 pwm_out[i] SHALL be registered: enable && (period_cnt < current[i]); current = 0 means always low, 2^DUTY_W-1 means always high.
REQ-025 pwm_oeb[i] SHALL equal !enable, registered.
REQ-026 While enable is low: prescaler and period counters held at 0, no period_end, pwm_out 0, current/target/pending retained, and commands still accepted while pending is empty.

Reset
REQ-027 Reset assertion SHALL immediately clear pwm_out, counters, current, target, pending, err, and cmd_ready, and set pwm_oeb to all ones.
REQ-028 cmd_ready SHALL go to 1 on the first clock after reset release.
REQ-029 Reset asserted mid-period or mid-ramp SHALL discard all in-flight state, with no partial application.

Structure
REQ-030 Package oto_pilot_pkg SHALL hold the parameter defaults (NUM_CH, DUTY_W, PRESC_W, SLEW) and the channel-index width function.
REQ-031 Per-channel target/current/slew/compare logic SHALL be sub-module oto_pilot_pwm_ch, generated NUM_CH times; the shared prescaler, period counter and command slot SHALL stay in oto_pilot_pwm.

Verification (NUM_CH=3, DUTY_W=8, SLEW=4, prescale=0)
REQ-032 Reset -> pwm_out=000, pwm_oeb=111, err=0, cmd_ready=0; one clock after release cmd_ready=1.
REQ-033 enable=1, cmd ch1 duty 8 -> cmd_ready=0 until the first period_end (255 cycles); ch1 high-time then 4 of 255 cycles, next period 8 of 255; ch0 and ch2 stay 0.
REQ-034 cmd ch0 duty 255 -> ramp +4 per period, pwm_out[0] constant high after 64 periods; then duty 0 -> ramps back down by 4, constant low.
REQ-035 cmd_valid held for two commands back-to-back -> second accepted only the cycle after the period_end that applies the first.
REQ-036 cmd ch3 duty 50 -> err=1 sticky, no channel change, cmd_ready returns to 1 after period_end.
REQ-037 enable dropped mid-period -> next cycle pwm_out=000, pwm_oeb=111; enable restored -> period restarts at 0 with prior current duties.

Source files
------------

// File: rtl/oto_pilot_pkg.sv
// Parameter defaults and the channel-index width helper for the oto_pilot
// PWM actuator block.
package oto_pilot_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int DUTY_W_DEF  = 8;
  localparam int PRESC_W_DEF = 8;
  localparam int SLEW_DEF    = 4;

  // A single-channel build still needs a one-bit channel field.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/oto_pilot_pwm_if.sv
// Command port of the oto_pilot PWM block: one channel/duty update per transfer.
interface oto_pilot_pwm_if #(
  parameter int CH_W   = 2,
  parameter int DUTY_W = 8
);

  // A command transfers on each rising clock edge where cmd_valid and cmd_ready
  // are both high; the master holds cmd_ch/cmd_duty stable while it waits.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  logic [DUTY_W-1:0] cmd_duty;

  modport master (output cmd_valid, output cmd_ch, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_duty, output cmd_ready);

endinterface

// File: rtl/oto_pilot_pwm_ch.sv
// One PWM actuator channel: target/current duty, slew limiting at period
// boundaries and the registered compare output.
module oto_pilot_pwm_ch
  import oto_pilot_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int SLEW   = SLEW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              period_end_i,
  input  logic              load_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [DUTY_W-1:0] period_cnt_i,
  output logic              pwm_o
);

  localparam logic [DUTY_W:0] SLEW_X = (DUTY_W + 1)'(SLEW);

  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] current_q, current_d;
  logic [DUTY_W-1:0] diff;
  logic              pwm_q, pwm_d;

  always_comb begin
    target_d  = load_i ? duty_i : target_q;
    current_d = current_q;
    diff      = '0;
    // A freshly loaded target already steers the step taken at this boundary.
    if (period_end_i) begin
      if (target_d > current_q) begin
        diff      = target_d - current_q;
        current_d = ({1'b0, diff} > SLEW_X) ? current_q + SLEW_X[DUTY_W-1:0] : target_d;
      end else if (target_d < current_q) begin
        diff      = current_q - target_d;
        current_d = ({1'b0, diff} > SLEW_X) ? current_q - SLEW_X[DUTY_W-1:0] : target_d;
      end
    end
    pwm_d = enable_i && (period_cnt_i < current_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target_q  <= '0;
      current_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      target_q  <= target_d;
      current_q <= current_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/oto_pilot_pwm.sv
// Multi-channel slew-limited PWM actuator driver: shared prescaler, period
// counter and one-entry command slot feeding NUM_CH channel instances.
module oto_pilot_pwm
  import oto_pilot_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int SLEW    = SLEW_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  oto_pilot_pwm_if.slave     cmd,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic [NUM_CH-1:0]  pwm_oeb,
  output logic               err
);

  localparam int CH_W = ch_idx_w(NUM_CH);
  // Period spans 2^DUTY_W-1 steps so an all-ones duty reads as fully on.
  localparam logic [DUTY_W-1:0] PER_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic               en_q, live_q;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d, presc_lim;
  logic [DUTY_W-1:0]  period_cnt_q, period_cnt_d;
  logic               pending_q, pending_d;
  logic [CH_W-1:0]    pend_ch_q, pend_ch_d;
  logic [DUTY_W-1:0]  pend_duty_q, pend_duty_d;
  logic               err_q, err_d;
  logic [NUM_CH-1:0]  oeb_q;
  logic               ready, rise, tick, period_end, accept, apply, in_range;

  assign ready         = live_q && !pending_q;
  assign cmd.cmd_ready = ready;

  always_comb begin
    rise       = enable && !en_q;
    // On the enable edge the fresh prescale value governs the very first step.
    presc_lim  = rise ? prescale : prescale_q;
    tick       = enable && (presc_cnt_q == presc_lim);
    period_end = tick && (period_cnt_q == PER_LAST);
    accept     = cmd.cmd_valid && ready;
    apply      = period_end && pending_q;
    in_range   = (int'(pend_ch_q) < NUM_CH);

    presc_cnt_d  = '0;
    period_cnt_d = '0;
    if (enable) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
      if (period_end)  period_cnt_d = '0;
      else if (tick)   period_cnt_d = period_cnt_q + DUTY_W'(1);
      else             period_cnt_d = period_cnt_q;
    end
    prescale_d = (rise || period_end) ? prescale : prescale_q;

    pending_d   = pending_q;
    pend_ch_d   = pend_ch_q;
    pend_duty_d = pend_duty_q;
    // ready is low while pending, so apply and accept never coincide.
    if (apply) begin
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d   = 1'b1;
      pend_ch_d   = cmd.cmd_ch;
      pend_duty_d = cmd.cmd_duty;
    end
    err_d = err_q || (apply && !in_range);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q         <= 1'b0;
      live_q       <= 1'b0;
      presc_cnt_q  <= '0;
      prescale_q   <= '0;
      period_cnt_q <= '0;
      pending_q    <= 1'b0;
      pend_ch_q    <= '0;
      pend_duty_q  <= '0;
      err_q        <= 1'b0;
      oeb_q        <= '1;
    end else begin
      en_q         <= enable;
      live_q       <= 1'b1;
      presc_cnt_q  <= presc_cnt_d;
      prescale_q   <= prescale_d;
      period_cnt_q <= period_cnt_d;
      pending_q    <= pending_d;
      pend_ch_q    <= pend_ch_d;
      pend_duty_q  <= pend_duty_d;
      err_q        <= err_d;
      oeb_q        <= {NUM_CH{!enable}};
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    oto_pilot_pwm_ch #(
      .DUTY_W (DUTY_W),
      .SLEW   (SLEW)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .enable_i     (enable),
      .period_end_i (period_end),
      .load_i       (apply && in_range && (pend_ch_q == CH_W'(i))),
      .duty_i       (pend_duty_q),
      .period_cnt_i (period_cnt_q),
      .pwm_o        (pwm_out[i])
    );
  end

  assign pwm_oeb = oeb_q;
  assign err     = err_q;

endmodule

// File: tb/tb_oto_pilot_pwm.sv
// Bench for oto_pilot_pwm: directed scenarios plus randomized commands and
// enable toggling, checked every cycle against a closed-form reference model.
module tb_oto_pilot_pwm;
  import oto_pilot_pkg::*;

  localparam int NUM_CH  = 3;
  localparam int DUTY_W  = 8;
  localparam int PRESC_W = 8;
  localparam int SLEW    = 4;
  localparam int CH_W    = ch_idx_w(NUM_CH);
  localparam int PER     = (1 << DUTY_W) - 1;
  localparam int MAXD    = PER;

  // ---------------- clock / reset ----------------
  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [PRESC_W-1:0] prescale = '0;
  logic [NUM_CH-1:0]  pwm_out, pwm_oeb;
  logic               err;

  oto_pilot_pwm_if #(.CH_W(CH_W), .DUTY_W(DUTY_W)) cmd_if ();

  oto_pilot_pwm #(
    .NUM_CH (NUM_CH), .DUTY_W (DUTY_W), .PRESC_W (PRESC_W), .SLEW (SLEW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .prescale (prescale),
    .cmd      (cmd_if.slave),
    .pwm_out  (pwm_out),
    .pwm_oeb  (pwm_oeb),
    .err      (err)
  );

  always #5 clock = ~clock;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  int                        m_tgt[NUM_CH];
  int                        m_cur[NUM_CH];
  bit                        m_live, m_prev_en, m_err, m_acc;
  int                        m_k, m_p;
  logic [CH_W+DUTY_W-1:0]    exp_q[$];
  logic [NUM_CH-1:0]         exp_pwm, exp_oeb;

  task automatic model_reset();
    foreach (m_tgt[i]) begin
      m_tgt[i] = 0;
      m_cur[i] = 0;
    end
    m_live = 0; m_prev_en = 0; m_err = 0; m_acc = 0; m_k = 0; m_p = 0;
    exp_q.delete();
    exp_pwm = '0;
    exp_oeb = '1;
  endtask

  // Advances the model over one clock edge using the inputs present at that edge.
  // Period position is derived from the count of enabled cycles since enable rose.
  task automatic model_step();
    bit                     pe;
    int                     pos, d, ch;
    logic [CH_W+DUTY_W-1:0] e;
    m_acc = cmd_if.cmd_valid && m_live && (exp_q.size() == 0);
    pe  = 0;
    pos = 0;
    if (enable) begin
      if (!m_prev_en) begin
        m_k = 0;
        m_p = int'(prescale);
      end else begin
        m_k++;
      end
      pos = (m_k / (m_p + 1)) % PER;
      pe  = ((m_k + 1) % ((m_p + 1) * PER)) == 0;
    end
    for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = enable && (pos < m_cur[i]);
    exp_oeb = enable ? '0 : '1;
    if (pe && exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ch = int'(e[CH_W+DUTY_W-1:DUTY_W]);
      if (ch < NUM_CH) m_tgt[ch] = int'(e[DUTY_W-1:0]);
      else             m_err = 1;
    end
    if (m_acc) exp_q.push_back({cmd_if.cmd_ch, cmd_if.cmd_duty});
    if (pe) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d = m_tgt[i] - m_cur[i];
        if (d > SLEW)  d = SLEW;
        if (d < -SLEW) d = -SLEW;
        m_cur[i] += d;
      end
    end
    m_live    = 1;
    m_prev_en = enable;
  endtask

  task automatic check_outputs();
    check_val("pwm_out",   pwm_out,          exp_pwm);
    check_val("pwm_oeb",   pwm_oeb,          exp_oeb);
    check_val("cmd_ready", cmd_if.cmd_ready, m_live && (exp_q.size() == 0));
    check_val("err",       err,              m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    cmd_if.cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    check_outputs();
    step();
    check_val("ready_after_release", cmd_if.cmd_ready, 1);
  endtask

  task automatic send_cmd(input int ch, input int duty);
    int guard;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = CH_W'(ch);
    cmd_if.cmd_duty  = DUTY_W'(duty);
    guard = 0;
    do begin
      step();
      guard++;
    end while (!m_acc && guard < 2000);
    check_val("accept_bound", guard < 2000, 1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (cmd_if.cmd_ready !== 1'b1 && guard < 3000) begin
      step();
      guard++;
    end
    check_val("ready_bound", guard < 3000, 1);
  endtask

  task automatic count_high(input int ch, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step();
      cnt += int'(pwm_out[ch]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, cnt0, cnt2, dsel;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_duty  = '0;
    model_reset();
    #3;
    do_reset();

    // Single command on ch1: ramps 4 then 8 per period.
    enable = 1'b1;
    send_cmd(1, 8);
    wait_ready();
    count_high(1, PER, cnt);
    check_val("ch1_first_period", cnt, 4);
    count_high(1, PER, cnt);
    check_val("ch1_second_period", cnt, 8);
    count_high(0, PER, cnt0);
    check_val("ch0_idle", cnt0, 0);
    count_high(2, PER, cnt2);
    check_val("ch2_idle", cnt2, 0);

    // Full-scale ramp up on ch0, then back down.
    send_cmd(0, MAXD);
    wait_ready();
    repeat (63 * PER) step();
    count_high(0, PER, cnt);
    check_val("ch0_full_on", cnt, PER);
    send_cmd(0, 0);
    wait_ready();
    repeat (64 * PER) step();
    count_high(0, PER, cnt);
    check_val("ch0_full_off", cnt, 0);

    // Back-to-back commands with valid held high.
    send_cmd(2, 100);
    send_cmd(2, 20);
    wait_ready();

    // Out-of-range channel sets the sticky error.
    send_cmd(3, 50);
    wait_ready();
    check_val("err_set", err, 1);
    repeat (PER) step();
    check_val("err_sticky", err, 1);

    // Enable dropped mid-period, command accepted while idle, then restart.
    repeat (100) step();
    enable = 1'b0;
    step();
    check_val("idle_pwm", pwm_out, 0);
    check_val("idle_oeb", pwm_oeb, 3'b111);
    send_cmd(1, 30);
    repeat (20) step();
    check_val("idle_pending_held", cmd_if.cmd_ready, 0);
    enable = 1'b1;
    repeat (3 * PER) step();

    // Randomized commands, duties and enable toggling.
    for (int run = 0; run < 4; run++) begin
      enable = 1'b0;
      prescale = PRESC_W'($urandom_range(0, 2));
      step();
      enable = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        if (!cmd_if.cmd_valid && $urandom_range(0, 99) < 5) begin
          dsel = $urandom_range(0, 3);
          cmd_if.cmd_valid = 1'b1;
          cmd_if.cmd_ch    = CH_W'($urandom_range(0, 3));
          cmd_if.cmd_duty  = (dsel == 0) ? '0 :
                             (dsel == 1) ? DUTY_W'(MAXD) : DUTY_W'($urandom_range(0, MAXD));
        end
        if ($urandom_range(0, 999) < 3) begin
          enable = !enable;
          if (!enable) prescale = PRESC_W'($urandom_range(0, 2));
        end
        step();
        if (m_acc) cmd_if.cmd_valid = 1'b0;
      end
      cmd_if.cmd_valid = 1'b0;
    end

    // Reset asserted mid-ramp discards everything in flight.
    enable = 1'b0;
    prescale = '0;
    step();
    enable = 1'b1;
    wait_ready();
    send_cmd(2, 200);
    repeat (600) step();
    do_reset();
    enable = 1'b1;
    repeat (2 * PER) step();
    check_val("post_reset_ch2_low", pwm_out[2], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
